// File: rtl/text_write_scheduler.sv
// text_write_scheduler: queues glyph codes, tracks the text cursor and paces one VRAM turn per glyph line into blanking.
// Optional macro TEXT_NEWLINE_EN turns code 63 into a newline instead of an invalid code.
module text_write_scheduler #(
  parameter int CHAR_W     = 8,
  parameter int CHAR_H     = 12,
  parameter int GLYPH_H    = 10,
  parameter int COLS       = 80,
  parameter int ROWS       = 40,
  parameter int FIFO_DEPTH = 16,
  parameter int TURN_GAP   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ch_valid_i,
  input  logic [5:0] ch_code_i,
  output logic       ch_ready_o,
  input  logic       blank_i,
  output logic [5:0] let_o,
  output logic [9:0] x_pos_o,
  output logic [8:0] y_pos_o,
  output logic       vram_turn_o,
  output logic       busy_o,
  output logic [6:0] cur_col_o,
  output logic [5:0] cur_row_o,
  output logic [7:0] drop_cnt_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(GLYPH_H);
  localparam int GW = $clog2(TURN_GAP);
`ifdef TEXT_NEWLINE_EN
  localparam bit NL_EN = 1'b1;
`else
  localparam bit NL_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, LOAD, WAIT_SLOT, LINE_GAP, ADVANCE} state_t;

  state_t        state_q, state_d;
  logic [5:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic [5:0]    code_q, code_d, let_q, let_d;
  logic [9:0]    x_q, x_d;
  logic [LW-1:0] line_q, line_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          nl_q, nl_d;
  logic [6:0]    col_q, col_d;
  logic [5:0]    row_q, row_d;
  logic [7:0]    drop_q, drop_d;
  logic          push, pop, turn, full, wrap_row;

  assign full     = cnt_q == (AW+1)'(FIFO_DEPTH);
  assign push     = ch_valid_i && ch_ready_o;
  assign wrap_row = nl_q || col_q == 7'(COLS - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_q + AW'(push);
      rd_q  <= rd_q + AW'(pop);
      cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= ch_code_i;
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    let_d   = let_q;
    x_d     = x_q;
    line_d  = line_q;
    gap_d   = gap_q;
    nl_d    = nl_q;
    col_d   = col_q;
    row_d   = row_q;
    drop_d  = drop_q;
    pop     = 1'b0;
    turn    = 1'b0;
    case (state_q)
      IDLE: if (cnt_q != '0) begin
        pop     = 1'b1;
        code_d  = mem_q[rd_q];
        state_d = LOAD;
      end
      LOAD: begin
        nl_d = NL_EN && code_q == 6'd63;
        if (code_q <= 6'd38) begin
          let_d   = code_q;
          x_d     = 10'(col_q) * 10'(CHAR_W);
          line_d  = '0;
          state_d = WAIT_SLOT;
        end else if (NL_EN && code_q == 6'd63) begin
          state_d = ADVANCE;
        end else begin
          drop_d  = drop_q + 8'(drop_q != 8'hFF);
          state_d = IDLE;
        end
      end
      WAIT_SLOT: if (blank_i) begin
        turn    = 1'b1;
        gap_d   = GW'(TURN_GAP - 2);
        state_d = LINE_GAP;
      end
      LINE_GAP: begin
        if (gap_q != '0) gap_d = gap_q - GW'(1);
        else if (line_q == LW'(GLYPH_H - 1)) state_d = ADVANCE;
        else begin
          line_d  = line_q + LW'(1);
          state_d = WAIT_SLOT;
        end
      end
      ADVANCE: begin
        col_d   = wrap_row ? '0 : col_q + 7'd1;
        row_d   = !wrap_row ? row_q : row_q == 6'(ROWS - 1) ? '0 : row_q + 6'd1;
        nl_d    = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      code_q  <= '0;
      let_q   <= '0;
      x_q     <= '0;
      line_q  <= '0;
      gap_q   <= '0;
      nl_q    <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      let_q   <= let_d;
      x_q     <= x_d;
      line_q  <= line_d;
      gap_q   <= gap_d;
      nl_q    <= nl_d;
      col_q   <= col_d;
      row_q   <= row_d;
      drop_q  <= drop_d;
    end
  end

  // every output is forced low while reset is asserted, even before the first reset edge
  assign ch_ready_o  = !rst && !full;
  assign vram_turn_o = !rst && turn;
  assign busy_o      = !rst && (state_q != IDLE || cnt_q != '0);
  assign let_o       = rst ? '0 : let_q;
  assign x_pos_o     = rst ? '0 : x_q;
  assign y_pos_o     = rst ? '0 : 9'(row_q) * 9'(CHAR_H) + 9'(line_q);
  assign cur_col_o   = rst ? '0 : col_q;
  assign cur_row_o   = rst ? '0 : row_q;
  assign drop_cnt_o  = rst ? '0 : drop_q;
endmodule

// File: tb/tb_text_write_scheduler.sv
// tb_text_write_scheduler: random and directed stimulus checked against a queue-based model of cursor, drops and turns.
module tb_text_write_scheduler;
`ifdef TEXT_NEWLINE_EN
  localparam bit NL = 1'b1;
`else
  localparam bit NL = 1'b0;
`endif

  logic       clk = 0, rst = 1, ch_valid = 0, ch_ready, blank = 1;
  logic [5:0] ch_code = 0, let_w, cur_row;
  logic [9:0] x_pos;
  logic [8:0] y_pos;
  logic       vram_turn, busy;
  logic [6:0] cur_col;
  logic [7:0] drop_cnt;

  text_write_scheduler dut (
    .clk(clk), .rst(rst), .ch_valid_i(ch_valid), .ch_code_i(ch_code), .ch_ready_o(ch_ready),
    .blank_i(blank), .let_o(let_w), .x_pos_o(x_pos), .y_pos_o(y_pos), .vram_turn_o(vram_turn),
    .busy_o(busy), .cur_col_o(cur_col), .cur_row_o(cur_row), .drop_cnt_o(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {int l; int x; int y;} ent_t;
  ent_t exp_q[$];
  int checks = 0, failures = 0, cyc = 0, pulses = 0, last_pc = -100, last_y = 0, last_x = 0;
  int m_col = 0, m_row = 0, m_drop = 0, push_cyc = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic void adv(input bit nl);
    if (nl || m_col == 79) begin
      m_col = 0;
      m_row = (m_row == 39) ? 0 : m_row + 1;
    end else m_col++;
  endfunction

  function automatic void model_push(input logic [5:0] c);
    if (c <= 38) begin
      for (int k = 0; k < 10; k++) exp_q.push_back('{int'(c), m_col * 8, m_row * 12 + k});
      adv(0);
    end else if (NL && c == 63) adv(1);
    else if (m_drop < 255) m_drop++;
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst && vram_turn) begin
      ent_t e;
      pulses++;
      last_y = int'(y_pos);
      last_x = int'(x_pos);
      chk("turn_in_blank", blank, 1);
      if (last_pc >= 0) chk("turn_spacing", (cyc - last_pc) >= 4, 1);
      last_pc = cyc;
      if (exp_q.size() == 0) chk("turn_unexpected", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("turn_let", let_w, e.l);
        chk("turn_x", x_pos, e.x);
        chk("turn_y", y_pos, e.y);
      end
    end
  end

  task automatic push(input logic [5:0] c);
    int n = 0;
    @(posedge clk); #1;
    while (!ch_ready && n < 2000) begin @(posedge clk); #1; n++; end
    if (!ch_ready) begin chk("push_timeout", 0, 1); return; end
    ch_valid = 1;
    ch_code  = c;
    model_push(c);
    @(posedge clk); #1;
    ch_valid = 0;
    push_cyc = cyc;
  endtask

  task automatic wait_pulses(input int n, input int budget);
    int k = 0;
    while (pulses < n && k < budget) begin @(negedge clk); #1; k++; end
    if (pulses < n) chk("pulse_timeout", pulses, n);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    do begin @(negedge clk); #1; k++; end while (busy && k < budget);
    if (busy) chk("idle_timeout", busy, 0);
  endtask

  task automatic chk_cursor(input string tag);
    chk({tag, "_col"}, cur_col, m_col);
    chk({tag, "_row"}, cur_row, m_row);
    chk({tag, "_drop"}, drop_cnt, m_drop);
  endtask

  initial begin
    int base, ry;
    repeat (3) begin
      @(negedge clk);
      chk("rst_outputs", {ch_ready, let_w, x_pos, y_pos, vram_turn, busy, cur_col, cur_row, drop_cnt}, 0);
    end
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("rel_ready", ch_ready, 1);
    chk("rel_busy", busy, 0);
    chk_cursor("rel");

    base = pulses;
    push(6'd5);
    wait_pulses(base + 1, 100);
    chk("first_latency", last_pc - push_cyc, 2);
    wait_pulses(base + 10, 200);
    chk("last_latency", last_pc - push_cyc, 38);
    wait_idle(100);
    chk("single_busy", busy, 0);
    chk("single_col", cur_col, 1);
    chk("single_exp_empty", exp_q.size(), 0);

    for (int i = 0; i < 79; i++) push(6'($urandom_range(0, 38)));
    wait_idle(5000);
    chk_cursor("wrap");
    chk("wrap_row1", cur_row, 1);
    chk("wrap_last_x", last_x, 632);

    if (NL) begin
      for (int i = 0; i < 38; i++) push(6'd63);
      for (int i = 0; i < 79; i++) push(6'($urandom_range(0, 38)));
      wait_idle(5000);
      chk_cursor("preset");
      push(6'd20);
      wait_idle(200);
      chk_cursor("full_wrap");
      chk("full_wrap_zero", {cur_col, cur_row}, 0);
    end

    base = pulses;
    ry = m_row;
    push(6'd7);
    wait_pulses(base + 3, 100);
    @(posedge clk); #1 blank = 0;
    repeat (50) @(posedge clk);
    #1;
    chk("gated_no_pulse", pulses, base + 3);
    blank = 1;
    @(negedge clk); #1;
    chk("resume_pulse", pulses, base + 4);
    chk("resume_y", last_y, ry * 12 + 3);
    wait_idle(200);
    chk_cursor("gate");

    base = pulses;
    push(6'd45);
    wait_idle(50);
    chk("invalid_drop", drop_cnt, 1);
    push(6'd63);
    wait_idle(50);
    chk("nl_drop", drop_cnt, NL ? 1 : 2);
    chk("invalid_no_pulse", pulses, base);
    chk_cursor("nl");

    for (int i = 0; i < 800; i++) begin
      @(posedge clk); #1;
      blank    = $urandom_range(0, 3) != 0;
      ch_valid = $urandom_range(0, 1);
      ch_code  = ($urandom_range(0, 9) == 0) ? 6'd63 :
                 ($urandom_range(0, 9) == 0) ? 6'($urandom_range(39, 62)) : 6'($urandom_range(0, 38));
      if (ch_valid && ch_ready) model_push(ch_code);
    end
    @(posedge clk); #1;
    ch_valid = 0;
    blank = 1;
    wait_idle(5000);
    chk_cursor("random");
    chk("random_exp_empty", exp_q.size(), 0);

    blank = 0;
    for (int i = 0; i < 16; i++) push(6'(i));
    chk("ready_before_full", ch_ready, 1);
    push(6'd16);
    chk("ready_full", ch_ready, 0);
    rst = 1;
    @(negedge clk);
    chk("rst_mid_turn", vram_turn, 0);
    chk("rst_mid_ready", ch_ready, 0);
    @(posedge clk); #1 rst = 0;
    blank = 1;
    exp_q.delete();
    m_col = 0; m_row = 0; m_drop = 0;
    last_pc = -100;
    base = pulses;
    @(negedge clk);
    chk("post_rst_ready", ch_ready, 1);
    repeat (60) @(negedge clk);
    chk("post_rst_no_pulse", pulses, base);
    chk("post_rst_busy", busy, 0);
    chk_cursor("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
